fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_pc_reg.sv | 26 ++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch/decode types, reset values and opcode constants
package fetch_unit_pkg;

  // Fetch sequencer: issue a request, then present the word until accepted
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  // Major opcodes, shared with the control decoder
  localparam logic [6:0] OPC_R     = 7'h33;
  localparam logic [6:0] OPC_I     = 7'h13;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_LW    = 7'h03;
  localparam logic [6:0] OPC_SW    = 7'h23;
  localparam logic [6:0] OPC_B     = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_AUIPC = 7'h17;

  // Force an address onto a word boundary; the low two bits are simply dropped
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - word-aligned fetch address register
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_en,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  output logic [31:0] pc_q
);

  // Redirect load wins over sequential increment; increment wraps modulo 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= align_word(RESET_PC);
    end else if (load_en) begin
      pc_q <= align_word(load_addr);
    end else if (inc_en) begin
      pc_q <= pc_q + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-state instruction fetch sequencer with redirect handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic        misaligned_o,
  output logic [31:0] retired_cnt_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         pc_inc;

  // Sequential advance only when the decoder takes the word and no redirect overrides it
  assign pc_inc = (state_q == ST_HOLD) && instr_ready_i && !redirect_i;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (pc_inc),
    .load_en   (redirect_i),
    .load_addr (redirect_target_i),
    .pc_q      (pc_q)
  );

  // Handshake outputs decode straight off the state flop
  assign imem_req_o    = (state_q == ST_FETCH);
  assign instr_valid_o = (state_q == ST_HOLD);
  assign imem_addr_o   = pc_q;

  // Fetch FSM with registered instruction, pc, retire count and misalignment flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      instr_o       <= NOP_INSTR;
      pc_o          <= RESET_PC;
      retired_cnt_o <= 32'd0;
      misaligned_o  <= 1'b0;
    end else begin
      misaligned_o <= redirect_i && (redirect_target_i[1:0] != 2'b00);
      case (state_q)
        ST_FETCH: begin
          // A redirect discards any word returned in the same cycle
          if (!redirect_i && imem_ready_i) begin
            instr_o <= imem_rdata_i;
            pc_o    <= pc_q;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The presented word retires if accepted, even alongside a redirect
          if (instr_ready_i) begin
            retired_cnt_o <= retired_cnt_o + 32'd1;
          end
          if (instr_ready_i || redirect_i) begin
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        misaligned_o;
  logic [31:0] retired_cnt_o;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ready_i      (imem_ready_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .pc_o              (pc_o),
    .instr_ready_i     (instr_ready_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .misaligned_o      (misaligned_o),
    .retired_cnt_o     (retired_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fetch_log[$];
  int          cyc_log[$];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  // Reference model: 0 = FETCH, 1 = HOLD
  logic        m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_misal;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 1'b0;
    m_pc    = RST_PC;
    m_cnt   = 32'd0;
    m_misal = 1'b0;
    sb.delete();
    fetch_log.delete();
    cyc_log.delete();
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model
  task automatic step(input logic rdy, input logic [31:0] rd, input logic irdy,
                      input logic redir, input logic [31:0] tgt);
    logic nxt_misal;
    imem_ready_i      = rdy;
    imem_rdata_i      = rd;
    instr_ready_i     = irdy;
    redirect_i        = redir;
    redirect_target_i = tgt;
    @(negedge clk);
    check_eq("req",   32'(imem_req_o),    32'(!m_state));
    check_eq("valid", 32'(instr_valid_o), 32'(m_state));
    check_eq("cnt",   retired_cnt_o,      m_cnt);
    check_eq("misal", 32'(misaligned_o),  32'(m_misal));
    if (!m_state) begin
      check_eq("addr", imem_addr_o, m_pc);
    end else begin
      check_eq("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        check_eq("instr", instr_o, sb[0].instr);
        check_eq("pc",    pc_o,    sb[0].pc);
      end
    end
    nxt_misal = redir && (tgt[1:0] != 2'b00);
    if (redir) begin
      if (m_state) begin
        if (irdy) m_cnt = m_cnt + 32'd1;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      m_pc    = {tgt[31:2], 2'b00};
      m_state = 1'b0;
    end else if (!m_state) begin
      if (rdy) begin
        sb.push_back('{pc: m_pc, instr: rd});
        fetch_log.push_back(m_pc);
        cyc_log.push_back(cyc);
        m_state = 1'b1;
      end
    end else if (irdy) begin
      if (sb.size() > 0) void'(sb.pop_front());
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
      m_state = 1'b0;
    end
    m_misal = nxt_misal;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset             = 1'b0;
    imem_ready_i      = 1'b0;
    imem_rdata_i      = 32'd0;
    instr_ready_i     = 1'b0;
    redirect_i        = 1'b0;
    redirect_target_i = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_instr", instr_o, NOP);
    check_eq("rst_pc",    pc_o, RST_PC);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_cnt",   retired_cnt_o, 32'd0);
    check_eq("rst_misal", 32'(misaligned_o), 32'd0);
    check_eq("rst_addr",  imem_addr_o, RST_PC);
    reset = 1'b1;
    cyc   = 1;

    // Zero-wait streaming of 0x33
    repeat (6) step(1'b1, 32'h0000_0033, 1'b1, 1'b0, 32'd0);
    check_eq("stream_cnt", retired_cnt_o, 32'd3);
    if (fetch_log.size() >= 3) begin
      check_eq("stream_a0", fetch_log[0], 32'h0040_0000);
      check_eq("stream_a1", fetch_log[1], 32'h0040_0004);
      check_eq("stream_a2", fetch_log[2], 32'h0040_0008);
      check_eq("stream_c0", 32'(cyc_log[0]), 32'd1);
      check_eq("stream_c1", 32'(cyc_log[1]), 32'd3);
      check_eq("stream_c2", 32'(cyc_log[2]), 32'd5);
    end else begin
      check_eq("stream_fetches", 32'(fetch_log.size()), 32'd3);
    end

    // Memory wait states, then a stalled decoder
    repeat (4) step(1'b0, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 32'h1234_5013, 1'b0, 1'b0, 32'd0);
    repeat (5) step(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Redirect in FETCH with data returning: data dropped, target aligned
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0040_0102);
    check_eq("redir_addr",  imem_addr_o, 32'h0040_0100);
    check_eq("redir_misal", 32'(misaligned_o), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'd0);

    // Redirect in HOLD while accepted: retires, jumps to top of memory
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check_eq("hold_redir_addr", imem_addr_o, 32'hFFFF_FFFC);
    step(1'b1, 32'h0000_0067, 1'b0, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check_eq("wrap_addr", imem_addr_o, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), $urandom());
    end

    // Reach HOLD, then reset asynchronously mid-cycle
    if (m_state) step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 32'hCAFE_0003, 1'b0, 1'b0, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("arst_instr", instr_o, NOP);
    check_eq("arst_pc",    pc_o, RST_PC);
    check_eq("arst_cnt",   retired_cnt_o, 32'd0);
    check_eq("arst_addr",  imem_addr_o, RST_PC);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 1;
    step(1'b1, 32'h0000_0037, 1'b1, 1'b0, 32'd0);
    step(1'b1, 32'h0000_0037, 1'b1, 1'b0, 32'd0);
    step(1'b1, 32'h0000_0017, 1'b1, 1'b0, 32'd0);
    if (fetch_log.size() > 0) check_eq("post_rst_addr", fetch_log[0], RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
